// File: rtl/instruction_sequencer_pkg.sv
// rtl/instruction_sequencer_pkg.sv - shared state encoding, opcode indices and NOP constant
package instruction_sequencer_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FETCH  = 2'd1;
   localparam logic [1:0] ST_DECODE = 2'd2;
   localparam logic [1:0] ST_EXEC   = 2'd3;

   localparam int OP_INOP = 0;
   localparam int OP_INOT = 15;

   localparam logic [15:0] NOP_ONEHOT = 16'h0001 << OP_INOP;

endpackage

// File: rtl/instruction_sequencer_decoder.sv
// rtl/instruction_sequencer_decoder.sv - instruction byte to one-hot opcode decoder
module instructionDecoder
   import instruction_sequencer_pkg::*;
(
   input  logic [7:0]  i_ir,
   output logic [15:0] o_onehot,
   output logic        o_illegal
);

   logic w_illegal;

   assign w_illegal = |i_ir[7:4];

   // Any byte with a nonzero upper nibble executes as a NOP and is flagged.
   always_comb begin
      o_onehot  = NOP_ONEHOT;
      o_illegal = w_illegal;
      if (!w_illegal) begin
         o_onehot = 16'h0001 << i_ir[3:0];
      end
   end

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/decode/execute sequencer with retire counter
module instruction_sequencer
   import instruction_sequencer_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [PC_W-1:0]  start_pc,
   input  logic             halt_req,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic             imem_ack,
   input  logic [7:0]       imem_rdata,
   output logic [15:0]      exec_onehot,
   output logic             exec_valid,
   input  logic             exec_done,
   input  logic             branch_taken,
   input  logic [PC_W-1:0]  branch_target,
   output logic             busy,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   logic [1:0]       r_state;
   logic [PC_W-1:0]  r_pc;
   logic [7:0]       r_ir;
   logic [15:0]      r_exec_onehot;
   logic             r_illegal;
   logic [CNT_W-1:0] r_retired;

   logic [15:0]      w_onehot;
   logic             w_illegal;
   logic             w_is_nop;
   logic [PC_W-1:0]  w_pc_inc;
   logic [CNT_W-1:0] w_retired_next;

   instructionDecoder u_decoder (
      .i_ir      (r_ir),
      .o_onehot  (w_onehot),
      .o_illegal (w_illegal)
   );

   assign w_is_nop       = (w_onehot == NOP_ONEHOT);
   assign w_pc_inc       = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
   assign w_retired_next = (&r_retired) ? r_retired : r_retired + {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_pc          <= '0;
         r_ir          <= '0;
         r_exec_onehot <= NOP_ONEHOT;
         r_illegal     <= 1'b0;
         r_retired     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_pc      <= start_pc;
                  r_illegal <= 1'b0;
                  r_retired <= '0;
                  r_state   <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  r_ir    <= imem_rdata;
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               r_exec_onehot <= w_onehot;
               if (w_illegal) begin
                  r_illegal <= 1'b1;
               end
               // NOPs retire straight from decode without visiting the execution unit.
               if (w_is_nop) begin
                  r_pc      <= w_pc_inc;
                  r_retired <= w_retired_next;
                  r_state   <= halt_req ? ST_IDLE : ST_FETCH;
               end else begin
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (exec_done) begin
                  r_pc      <= branch_taken ? branch_target : w_pc_inc;
                  r_retired <= w_retired_next;
                  r_state   <= halt_req ? ST_IDLE : ST_FETCH;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign imem_req    = (r_state == ST_FETCH);
   assign imem_addr   = r_pc;
   assign exec_valid  = (r_state == ST_EXEC);
   assign exec_onehot = r_exec_onehot;
   assign busy        = (r_state != ST_IDLE);
   assign illegal     = r_illegal;
   assign retired     = r_retired;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - directed self-checking bench for instruction_sequencer
module tb_instruction_sequencer;

   localparam int PC_W  = 8;
   localparam int CNT_W = 3;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic [PC_W-1:0]  start_pc;
   logic             halt_req;
   logic             imem_req;
   logic [PC_W-1:0]  imem_addr;
   logic             imem_ack;
   logic [7:0]       imem_rdata;
   logic [15:0]      exec_onehot;
   logic             exec_valid;
   logic             exec_done;
   logic             branch_taken;
   logic [PC_W-1:0]  branch_target;
   logic             busy;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   logic [7:0] mem [256];
   int done_delay;
   int r_cnt;
   int total;
   int bad;

   instruction_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .start_pc      (start_pc),
      .halt_req      (halt_req),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .exec_onehot   (exec_onehot),
      .exec_valid    (exec_valid),
      .exec_done     (exec_done),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .busy          (busy),
      .illegal       (illegal),
      .retired       (retired)
   );

   always #5 clk = ~clk;

   // Memory acks immediately; execution unit answers after done_delay EXEC cycles.
   assign imem_ack   = imem_req;
   assign imem_rdata = mem[imem_addr];
   assign exec_done  = exec_valid && (r_cnt == done_delay);

   always @(posedge clk) begin
      if (exec_valid && !exec_done) r_cnt <= r_cnt + 1;
      else                          r_cnt <= 0;
   end

   task automatic start_at(input logic [7:0] pc);
      start_pc = pc;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic stop_run;
      halt_req = 1'b1;
      for (int i = 0; i < 50 && busy; i++) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL halt_timeout: busy=%0b want 0", busy); end
      halt_req = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b want 0", imem_req); end
      total++; if (exec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", exec_valid); end
      total++; if (exec_onehot !== 16'h0001) begin bad++; $display("FAIL reset_onehot: got %h want 0001", exec_onehot); end
      total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %0b want 0", illegal); end
      total++; if (retired !== 3'd0) begin bad++; $display("FAIL reset_retired: got %0d want 0", retired); end
      reset_n = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %0b want 0", busy); end
   endtask

   task automatic test_nop_stream;
      done_delay = 0;
      start_at(8'h10);
      for (int k = 0; k < 3; k++) begin
         total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL nop_req%0d: got %0b want 1", k, imem_req); end
         total++; if (imem_addr !== 8'h10 + k[7:0]) begin bad++; $display("FAIL nop_addr%0d: got %h want %h", k, imem_addr, 8'h10 + k[7:0]); end
         total++; if (retired !== k[2:0]) begin bad++; $display("FAIL nop_retired%0d: got %0d want %0d", k, retired, k); end
         @(negedge clk);
         total++; if (imem_req !== 1'b0 || exec_valid !== 1'b0) begin bad++; $display("FAIL nop_decode%0d: req=%0b valid=%0b want 0 0", k, imem_req, exec_valid); end
         if (k == 1) begin
            start_pc = 8'h99;
            start    = 1'b1;
         end
         @(negedge clk);
         start = 1'b0;
      end
      total++; if (imem_addr !== 8'h13) begin bad++; $display("FAIL nop_start_ignored: got %h want 13", imem_addr); end
      stop_run();
   endtask

   task automatic test_exec_delay;
      int n;
      int unstable;
      mem[8'h20] = 8'h05;
      done_delay = 4;
      n = 0;
      unstable = 0;
      start_at(8'h20);
      @(negedge clk);
      total++; if (exec_valid !== 1'b0) begin bad++; $display("FAIL delay_decode_valid: got %0b want 0", exec_valid); end
      @(negedge clk);
      while (exec_valid && n < 20) begin
         if (exec_onehot !== 16'h0020) unstable++;
         n++;
         @(negedge clk);
      end
      total++; if (n != 5) begin bad++; $display("FAIL delay_valid_cycles: got %0d want 5", n); end
      total++; if (unstable != 0) begin bad++; $display("FAIL delay_onehot: bad cycles %0d want 0 (onehot %h want 0020)", unstable, exec_onehot); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 8'h21) begin bad++; $display("FAIL delay_next_fetch: req=%0b addr=%h want 1 21", imem_req, imem_addr); end
      total++; if (retired !== 3'd1) begin bad++; $display("FAIL delay_retired: got %0d want 1", retired); end
      stop_run();
   endtask

   task automatic test_wrap;
      mem[8'hFF] = 8'h0F;
      done_delay = 0;
      start_at(8'hFF);
      @(negedge clk);
      @(negedge clk);
      total++; if (exec_valid !== 1'b1 || exec_onehot !== 16'h8000) begin bad++; $display("FAIL wrap_onehot: valid=%0b onehot=%h want 1 8000", exec_valid, exec_onehot); end
      @(negedge clk);
      total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin bad++; $display("FAIL wrap_addr: req=%0b addr=%h want 1 00", imem_req, imem_addr); end
      stop_run();
   endtask

   task automatic test_illegal;
      mem[8'h30] = 8'hA3;
      start_at(8'h30);
      @(negedge clk);
      total++; if (exec_valid !== 1'b0) begin bad++; $display("FAIL ill_decode_valid: got %0b want 0", exec_valid); end
      @(negedge clk);
      total++; if (exec_valid !== 1'b0 || imem_addr !== 8'h31) begin bad++; $display("FAIL ill_next: valid=%0b addr=%h want 0 31", exec_valid, imem_addr); end
      total++; if (exec_onehot !== 16'h0001) begin bad++; $display("FAIL ill_onehot: got %h want 0001", exec_onehot); end
      total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_flag: got %0b want 1", illegal); end
      total++; if (retired !== 3'd1) begin bad++; $display("FAIL ill_retired: got %0d want 1", retired); end
      repeat (2) @(negedge clk);
      total++; if (illegal !== 1'b1 || retired !== 3'd2) begin bad++; $display("FAIL ill_sticky: illegal=%0b retired=%0d want 1 2", illegal, retired); end
      stop_run();
      total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_idle_sticky: got %0b want 1", illegal); end
   endtask

   task automatic test_branch;
      mem[8'h50] = 8'h03;
      done_delay = 0;
      branch_taken  = 1'b1;
      branch_target = 8'h40;
      start_at(8'h50);
      total++; if (illegal !== 1'b0) begin bad++; $display("FAIL br_illegal_clear: got %0b want 0", illegal); end
      @(negedge clk);
      @(negedge clk);
      total++; if (exec_onehot !== 16'h0008) begin bad++; $display("FAIL br_onehot: got %h want 0008", exec_onehot); end
      @(negedge clk);
      branch_taken = 1'b0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin bad++; $display("FAIL br_target: req=%0b addr=%h want 1 40", imem_req, imem_addr); end
      stop_run();
   endtask

   task automatic test_halt_and_reset;
      int seen;
      int stray;
      mem[8'h60] = 8'h02;
      done_delay = 2;
      seen = 0;
      stray = 0;
      start_at(8'h60);
      @(negedge clk);
      @(negedge clk);
      halt_req = 1'b1;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (exec_done) seen = 1;
         else @(negedge clk);
      end
      total++; if (seen != 1 || busy !== 1'b1) begin bad++; $display("FAIL halt_done_seen: seen=%0d busy=%0b want 1 1", seen, busy); end
      @(negedge clk);
      total++; if (busy !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL halt_stop: busy=%0b req=%0b want 0 0", busy, imem_req); end
      total++; if (retired !== 3'd1) begin bad++; $display("FAIL halt_retired: got %0d want 1", retired); end
      repeat (3) begin
         @(negedge clk);
         if (imem_req !== 1'b0) stray++;
      end
      total++; if (stray != 0) begin bad++; $display("FAIL halt_no_fetch: stray=%0d want 0", stray); end
      halt_req = 1'b0;
      start_at(8'h70);
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_pre_req: got %0b want 1", imem_req); end
      #2 reset_n = 1'b0;
      #1;
      total++; if (imem_req !== 1'b0 || busy !== 1'b0 || exec_valid !== 1'b0) begin bad++; $display("FAIL rst_async: req=%0b busy=%0b valid=%0b want 0 0 0", imem_req, busy, exec_valid); end
      @(negedge clk);
      reset_n = 1'b1;
      total++; if (retired !== 3'd0) begin bad++; $display("FAIL rst_retired: got %0d want 0", retired); end
   endtask

   task automatic test_saturate;
      done_delay = 0;
      start_at(8'h80);
      repeat (20) @(negedge clk);
      total++; if (retired !== 3'd7 || busy !== 1'b1) begin bad++; $display("FAIL sat_retired: retired=%0d busy=%0b want 7 1", retired, busy); end
      stop_run();
      total++; if (retired !== 3'd7) begin bad++; $display("FAIL sat_hold: got %0d want 7", retired); end
   endtask

   initial begin
      clk = 1'b0;
      reset_n = 1'b0;
      start = 1'b0;
      start_pc = '0;
      halt_req = 1'b0;
      branch_taken = 1'b0;
      branch_target = '0;
      done_delay = 0;
      total = 0;
      bad = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      test_reset();
      test_nop_stream();
      test_exec_delay();
      test_wrap();
      test_illegal();
      test_branch();
      test_halt_and_reset();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
